// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM state encoding,
// RV32I width codes and the request legality check.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Stores have no unsigned variants, so any store with funct3[2] set is illegal.
  function automatic logic req_error(input logic we, input logic [2:0] funct3,
                                     input logic [1:0] addr_lo);
    logic illegal;
    logic misaligned;
    illegal    = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111) ||
                 (we && funct3[2]);
    misaligned = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                 ((funct3 == F3_W) && (addr_lo != 2'b00));
    return illegal || misaligned;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// CPU-side request/response channel of the load/store unit.
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// rsp_valid is a single-cycle pulse, rsp_rdata/rsp_err meaningful only while it is high.
interface lsu_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts/extends load data from a memory word and
// merges store data into the selected byte or halfword lane.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] mem_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = mem_word[7:0];
    case (lane)
      2'd1:    byte_sel = mem_word[15:8];
      2'd2:    byte_sel = mem_word[23:16];
      2'd3:    byte_sel = mem_word[31:24];
      default: byte_sel = mem_word[7:0];
    endcase
    half_sel = lane[1] ? mem_word[31:16] : mem_word[15:0];

    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data = {24'd0, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data = {16'd0, half_sel};
      default: load_data = mem_word;
    endcase

    store_word = mem_word;
    case (funct3)
      F3_B: begin
        case (lane)
          2'd1:    store_word[15:8]  = wdata[7:0];
          2'd2:    store_word[23:16] = wdata[7:0];
          2'd3:    store_word[31:24] = wdata[7:0];
          default: store_word[7:0]   = wdata[7:0];
        endcase
      end
      F3_H: begin
        if (lane[1]) store_word[31:16] = wdata[15:0];
        else         store_word[15:0]  = wdata[15:0];
      end
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one outstanding request, sub-word stores done as
// read-modify-write against a single-cycle data memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
)(
  input  logic              clk,
  input  logic              rst_n,
  lsu_if.slave              cpu,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output lsu_state_e        dbg_state
);

  lsu_state_e        state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [31:0]       wdata_q;
  logic [31:0]       data_q;
  logic              err_q;
  logic              accept;
  logic              req_err;
  logic [31:0]       load_data;
  logic [31:0]       store_word;

  assign accept  = cpu.req_valid && cpu.req_ready;
  assign req_err = req_error(cpu.req_we, cpu.req_funct3, cpu.req_addr[1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      wdata_q <= 32'd0;
      err_q   <= 1'b0;
      data_q  <= 32'd0;
    end else begin
      if (accept) begin
        addr_q  <= cpu.req_addr;
        we_q    <= cpu.req_we;
        f3_q    <= cpu.req_funct3;
        wdata_q <= cpu.req_wdata;
        err_q   <= req_err;
      end
      if (state == ST_RD) data_q <= mem_rdata;
    end
  end

  // Full-word stores skip the read; everything else that is legal reads first.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (req_err)                                      state_nxt = ST_RESP;
          else if (cpu.req_we && (cpu.req_funct3 == F3_W))  state_nxt = ST_WR;
          else                                              state_nxt = ST_RD;
        end
      end
      ST_RD:   state_nxt = we_q ? ST_WR : ST_RESP;
      ST_WR:   state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  lsu_align u_align (
    .funct3     (f3_q),
    .lane       (addr_q[1:0]),
    .mem_word   (data_q),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  // SW never passes through RD, so its write data comes straight from wdata_q.
  always_comb begin
    mem_read      = (state == ST_RD);
    mem_write     = (state == ST_WR);
    mem_addr      = (mem_read || mem_write) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    mem_wdata     = 32'd0;
    if (mem_write) mem_wdata = (f3_q == F3_W) ? wdata_q : store_word;
    cpu.req_ready = (state == ST_IDLE);
    cpu.rsp_valid = (state == ST_RESP);
    cpu.rsp_err   = (state == ST_RESP) && err_q;
    cpu.rsp_rdata = ((state == ST_RESP) && !err_q && !we_q) ? load_data : 32'd0;
    dbg_state     = state;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width of the request and memory address buses.
REQ-002 SHALL have one clock; reset is asynchronous and active-low; ports clk and rst_n.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req_valid  input  1  CPU request present.
REQ-006 req_ready  output  1  unit accepts request; high only in IDLE.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_funct3  input  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 req_addr  input  ADDR_W  byte address.
REQ-010 req_wdata  input  32  store data, right-aligned.
REQ-011 rsp_valid  output  1  one-cycle completion pulse.
REQ-012 rsp_rdata  output  32  load result, extended; 0 for stores and errors.
REQ-013 rsp_err  output  1  misaligned address or illegal funct3; qualified by rsp_valid.
REQ-014 mem_read, mem_write  output  1 each  data-memory enables; never both high.
REQ-015 mem_addr  output  ADDR_W  word-aligned address {addr_q[ADDR_W-1:2],2'b00}.
REQ-016 mem_wdata  output  32  full word to write.
REQ-017 mem_rdata  input  32  combinational read data, valid in the same cycle as mem_read.

Function
REQ-018 SHALL register addr, we, funct3, wdata on the edge where req_valid && req_ready.
REQ-019 FSM states: IDLE, RD, WR, RESP; mem_read = (state==RD), mem_write = (state==WR), rsp_valid = (state==RESP).
REQ-020 IDLE accept: illegal funct3 (011,110,111, or store with 1xx) or misaligned (H/HU addr[0]!=0, W addr[1:0]!=0) -> RESP with err=1, no memory access.
REQ-021 IDLE accept: load -> RD; SW -> WR; SB/SH -> RD (read-modify-write).
REQ-022 RD: capture mem_rdata at end of cycle; load -> RESP; sub-word store -> WR.
REQ-023 WR: mem_wdata = captured word with selected byte/halfword lane(s) replaced from wdata (SW: wdata unchanged); -> RESP.
REQ-024 RESP: one cycle, -> IDLE; back-to-back requests: next accept no earlier than cycle after RESP.
REQ-025 Latency from accept edge to rsp_valid: load 2 cycles, SW 2, SB/SH 3, error 1.
REQ-026 Load extraction: lane = addr[1:0] (B) or addr[1] (H); B/H sign-extend, BU/HU zero-extend, W unchanged.
REQ-027 req_valid while not in IDLE SHALL be ignored (no queueing); req_* may change freely outside acceptance.
REQ-028 mem_addr and mem_wdata SHALL be 0 when neither enable is high.

Reset
REQ-029 rst_n low SHALL force state IDLE and asynchronously drive mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0; req_ready=1 while held.
REQ-030 Reset mid-operation SHALL abort the transaction; no memory write and no response are issued for it after release.

Structure
REQ-031 Package lsu_pkg SHALL hold the state enum and funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
REQ-032 One combinational sub-module lsu_align SHALL perform lane extraction/extension and store-lane merge; FSM and registers remain in load_store_unit.

Verification
REQ-033 Memory word 0x100 = 0x8077_F0A5; LB addr 0x101 -> one RD cycle, rsp_rdata=0xFFFF_FFF0, err=0, 2 cycles after accept.
REQ-034 Same word; LHU addr 0x102 -> rsp_rdata=0x0000_8077; LH addr 0x102 -> 0xFFFF_8077.
REQ-035 SB addr 0x103, wdata 0x0000_0012 -> RD then WR with mem_wdata=0x1277_F0A5, rsp_valid 3 cycles after accept; subsequent LW 0x100 returns 0x1277_F0A5.
REQ-036 LW addr 0x102 and funct3=011 -> rsp_err=1 after 1 cycle, mem_read and mem_write never asserted.
REQ-037 SW 0x200 accepted, rst_n low during RD/WR -> mem_write drops immediately, no rsp_valid, req_ready=1; LW 0x200 after release returns the pre-existing value.
REQ-038 req_valid held high for 10 cycles with LW -> requests accepted only in IDLE, one rsp_valid per accept, req_ready low in RD/RESP.
